// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: widths, PC-1/PC-2 tables, shift schedule,
// FSM state type and the half-wise rotate/permutation helpers.
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int CD_W     = 56;
  localparam int HALF_W   = 28;
  localparam int SUBKEY_W = 48;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } des_state_e;

  // Entries are 1-based DES bit numbers, MSB first (DES bit 1 = vector MSB).
  localparam int PC1_TABLE [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TABLE [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFTS [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < CD_W; i++) r[6'(CD_W-1-i)] = k[6'(KEY_W-PC1_TABLE[i])];
    return r;
  endfunction

  // Only shift amounts of 1 and 2 ever occur in DES.
  function automatic logic [HALF_W-1:0] rol28(input logic [HALF_W-1:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [HALF_W-1:0] ror28(input logic [HALF_W-1:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  function automatic logic [CD_W-1:0] rotl_cd(input logic [CD_W-1:0] cd, input logic [1:0] n);
    return {rol28(cd[55:28], n), rol28(cd[27:0], n)};
  endfunction

  function automatic logic [CD_W-1:0] rotr_cd(input logic [CD_W-1:0] cd, input logic [1:0] n);
    return {ror28(cd[55:28], n), ror28(cd[27:0], n)};
  endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Request/subkey bus of the DES key scheduler. Optional parity_err exists only
// when DES_KEY_PARITY_CHECK_EN is defined.
interface des_key_schedule_if;
  import des_pkg::*;

  // Handshake: a subkey transfers on every rising edge where subkey_valid and
  // subkey_ready are both high; while valid && !ready, subkey and round hold.
  logic                start;
  logic [KEY_W-1:0]    key;
  logic                decrypt;
  logic [SUBKEY_W-1:0] subkey;
  logic                subkey_valid;
  logic                subkey_ready;
  logic [3:0]          round;
  logic                busy;
  logic                done;
  des_state_e          state;
`ifdef DES_KEY_PARITY_CHECK_EN
  logic                parity_err;
`endif

  modport master (
    output start, key, decrypt, subkey_ready,
    input  subkey, subkey_valid, round, busy, done, state
`ifdef DES_KEY_PARITY_CHECK_EN
    , input parity_err
`endif
  );

  modport slave (
    input  start, key, decrypt, subkey_ready,
    output subkey, subkey_valid, round, busy, done, state
`ifdef DES_KEY_PARITY_CHECK_EN
    , output parity_err
`endif
  );

endinterface

// File: rtl/des_pc2.sv
// Combinational DES PC-2: 56-bit C/D state in, 48-bit round subkey out.
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0]     cd,
  output logic [SUBKEY_W-1:0] subkey
);

  always_comb begin
    subkey = '0;
    for (int i = 0; i < SUBKEY_W; i++) subkey[6'(SUBKEY_W-1-i)] = cd[6'(CD_W-PC2_TABLE[i])];
  end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES round-key generator, one subkey per handshake, encrypt or decrypt
// order. Define DES_KEY_PARITY_CHECK_EN to reject keys with an even-parity byte.
module des_key_schedule
  import des_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  des_key_schedule_if.slave bus
);

  des_state_e          state_q, state_d;
  logic [CD_W-1:0]     cd_q;
  logic [CD_W-1:0]     cd_start, cd_step;
  logic [3:0]          round_q;
  logic                dec_q;
  logic                done_q;
  logic [1:0]          step;
  logic                start_ok;
  logic                accept;
  logic                valid;
  logic                handshake;
  logic                last_hs;
  logic [SUBKEY_W-1:0] pc2_out;

`ifdef DES_KEY_PARITY_CHECK_EN
  logic parity_ok;
  logic parity_err_q;

  always_comb begin
    parity_ok = 1'b1;
    for (int b = 0; b < 8; b++) parity_ok = parity_ok & (^bus.key[8*b +: 8]);
  end

  assign start_ok = parity_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               parity_err_q <= 1'b0;
    else if (state_q == ST_IDLE && bus.start) parity_err_q <= !parity_ok;
  end

  assign bus.parity_err = parity_err_q;
`else
  assign start_ok = 1'b1;
`endif

  assign accept    = (state_q == ST_IDLE) && bus.start && start_ok;
  assign handshake = valid && bus.subkey_ready;
  assign last_hs   = handshake && (round_q == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)  state_d = ST_RUN;
      ST_RUN:  if (last_hs) state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid = 1'b0;
    case (state_q)
      ST_RUN:  valid = 1'b1;
      default: valid = 1'b0;
    endcase
  end

  // Encrypt walks C1..C16 forward; decrypt starts at C16 (= C0) and walks back.
  always_comb begin
    step     = dec_q ? SHIFTS[4'd15 - round_q] : SHIFTS[round_q + 4'd1];
    cd_step  = dec_q ? rotr_cd(cd_q, step) : rotl_cd(cd_q, step);
    cd_start = bus.decrypt ? pc1(bus.key) : rotl_cd(pc1(bus.key), 2'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd_q    <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last_hs;
      if (accept) begin
        cd_q    <= cd_start;
        round_q <= '0;
        dec_q   <= bus.decrypt;
      end else if (handshake && !last_hs) begin
        cd_q    <= cd_step;
        round_q <= round_q + 4'd1;
      end
    end
  end

  des_pc2 u_pc2 (
    .cd     (cd_q),
    .subkey (pc2_out)
  );

  assign bus.subkey       = pc2_out;
  assign bus.subkey_valid = valid;
  assign bus.busy         = valid;
  assign bus.round        = round_q;
  assign bus.done         = done_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: directed DES vectors plus random keys
// scored against a cumulative-shift reference model of the DES key schedule.
module tb_des_key_schedule;
  import des_pkg::*;

  localparam logic [63:0] KEY_REF = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD = 64'h123457799BBCDFF1;
  localparam logic [47:0] K1_REF  = 48'h1B02EFFC7072;
  localparam logic [47:0] K2_REF  = 48'h79AED9DBC9E5;
  localparam logic [47:0] K16_REF = 48'hCB3D8B0E17F5;

  localparam int PC1_M [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_M [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFT_M [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc_cnt;

  logic [47:0] exp_q [$];
  logic [47:0] obs_sk [16];

  des_key_schedule_if bus ();

  des_key_schedule dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Subkey of DES round r (1..16): C/D rotated left by the cumulative shift count.
  function automatic logic [47:0] model_subkey(input logic [63:0] k, input int r);
    logic [27:0] c0, d0;
    logic [55:0] cd;
    logic [47:0] sk;
    int tot;
    for (int i = 0; i < 28; i++) begin
      c0[5'(27-i)] = k[6'(64-PC1_M[i])];
      d0[5'(27-i)] = k[6'(64-PC1_M[28+i])];
    end
    tot = 0;
    for (int j = 0; j < r; j++) tot += SHIFT_M[j];
    for (int p = 0; p < 28; p++) begin
      cd[6'(55-p)] = c0[5'(27-((p+tot)%28))];
      cd[6'(27-p)] = d0[5'(27-((p+tot)%28))];
    end
    for (int i = 0; i < 48; i++) sk[6'(47-i)] = cd[6'(56-PC2_M[i])];
    return sk;
  endfunction

  function automatic logic [63:0] fix_parity(input logic [63:0] k);
    logic [63:0] r;
    r = k;
    for (int b = 0; b < 8; b++) r[8*b] = ~^r[8*b+1 +: 7];
    return r;
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_sched(input logic [63:0] k, input logic dec,
                           input int stall_at, input int stall_len, input int intr_at);
    int idx, stalls, guard, t0;
    bit intr_done;
    idx = 0; stalls = 0; guard = 0; intr_done = 0;
    exp_q.delete();
    for (int e = 0; e < 16; e++) exp_q.push_back(model_subkey(k, dec ? 16 - e : e + 1));
    t0 = cyc_cnt;
    bus.start = 1'b1; bus.key = k; bus.decrypt = dec; bus.subkey_ready = 1'b1;
    @(negedge clk);
    while (idx < 16 && guard < 80) begin
      bus.start = 1'b0;
      check("valid", 64'(bus.subkey_valid), 64'd1);
      check("busy", 64'(bus.busy), 64'd1);
      check("done_low", 64'(bus.done), 64'd0);
      check("round", 64'(bus.round), 64'(idx));
      check("subkey", 64'(bus.subkey), 64'(exp_q[0]));
      if (idx == intr_at && !intr_done) begin
        bus.start = 1'b1; bus.key = 64'd0; bus.decrypt = 1'b1; intr_done = 1;
      end
      if (idx == stall_at && stalls < stall_len) begin
        bus.subkey_ready = 1'b0;
        stalls++;
      end else begin
        bus.subkey_ready = 1'b1;
        obs_sk[idx] = bus.subkey;
        void'(exp_q.pop_front());
        idx++;
      end
      @(negedge clk);
      guard++;
    end
    bus.start = 1'b0;
    bus.subkey_ready = 1'b1;
    check("sched_complete", 64'(idx), 64'd16);
    check("done_pulse", 64'(bus.done), 64'd1);
    check("done_latency", 64'(cyc_cnt - t0), 64'(17 + stall_len));
    check("valid_after", 64'(bus.subkey_valid), 64'd0);
    check("busy_after", 64'(bus.busy), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    logic [63:0] rk;
    logic rd;
    checks = 0; errors = 0; cyc_cnt = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.key = '0; bus.decrypt = 1'b0; bus.subkey_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    check("rst_valid", 64'(bus.subkey_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_round", 64'(bus.round), 64'd0);
    check("rst_subkey", 64'(bus.subkey), 64'd0);
    check("rst_state", 64'(bus.state), 64'(ST_IDLE));
`ifdef DES_KEY_PARITY_CHECK_EN
    check("rst_parity_err", 64'(bus.parity_err), 64'd0);
`endif
    @(negedge clk);

    // Encrypt order, then decrypt started in the done cycle.
    run_sched(KEY_REF, 1'b0, -1, 0, -1);
    check("enc_k1", 64'(obs_sk[0]), 64'(K1_REF));
    check("enc_k2", 64'(obs_sk[1]), 64'(K2_REF));
    check("enc_k16", 64'(obs_sk[15]), 64'(K16_REF));
    run_sched(KEY_REF, 1'b1, -1, 0, -1);
    check("dec_r0", 64'(obs_sk[0]), 64'(K16_REF));
    check("dec_r14", 64'(obs_sk[14]), 64'(K2_REF));
    check("dec_r15", 64'(obs_sk[15]), 64'(K1_REF));

    // Backpressure at round 3, then an ignored start at round 7.
    @(negedge clk);
    run_sched(KEY_REF, 1'b0, 3, 5, -1);
    check("bp_k1", 64'(obs_sk[0]), 64'(K1_REF));
    check("bp_k16", 64'(obs_sk[15]), 64'(K16_REF));
    @(negedge clk);
    run_sched(KEY_REF, 1'b0, -1, 0, 7);
    check("busy_start_k16", 64'(obs_sk[15]), 64'(K16_REF));

    // Asynchronous reset in the middle of round 9.
    @(negedge clk);
    bus.start = 1'b1; bus.key = KEY_REF; bus.decrypt = 1'b0; bus.subkey_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    guard = 0;
    while (bus.round != 4'd9 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("reach_round9", 64'(bus.round), 64'd9);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.subkey_valid), 64'd0);
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_round", 64'(bus.round), 64'd0);
    check("arst_subkey", 64'(bus.subkey), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_sched(KEY_REF, 1'b0, -1, 0, -1);
    check("arst_k1", 64'(obs_sk[0]), 64'(K1_REF));

`ifdef DES_KEY_PARITY_CHECK_EN
    // Even-parity byte rejects the start; a good key clears the flag.
    @(negedge clk);
    bus.start = 1'b1; bus.key = KEY_BAD; bus.decrypt = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    check("par_err_set", 64'(bus.parity_err), 64'd1);
    check("par_no_run", 64'(bus.subkey_valid), 64'd0);
    @(negedge clk);
    check("par_still_idle", 64'(bus.busy), 64'd0);
    run_sched(KEY_REF, 1'b0, -1, 0, -1);
    check("par_err_clear", 64'(bus.parity_err), 64'd0);
    check("par_k1", 64'(obs_sk[0]), 64'(K1_REF));
`endif

    // Random keys, directions, stalls and ignored starts.
    for (int n = 0; n < 10; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rk = fix_parity({$urandom, $urandom});
      rd = 1'($urandom_range(0, 1));
      run_sched(rk, rd, int'($urandom_range(0, 15)), int'($urandom_range(0, 4)),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
